// File: rtl/data_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_ram_responder
//  Purpose  : Data RAM serving memory_control LDR/STR/ADR traffic. Accepts one
//             access per request, waits WAIT_CYCLES wait states, then performs
//             the access and pulses mem_ready for one cycle.
//  Options  : define OOR_CHECK_EN to flag/suppress accesses whose address has
//             any bit set above the word index (requires ADDR_BITS < 32).
//  Revision : 1.0  initial release
// ============================================================================
module data_ram_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memory_enable,
  input  logic              RW,
  input  logic              str_enable,
  input  logic [31:0]       address_in,
  input  logic [DATA_W-1:0] RAM_in,
  output logic [DATA_W-1:0] RAM_out,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam int          DEPTH    = 2 ** ADDR_BITS;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [DATA_W-1:0] OOR_READ_VALUE = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0]    mem [DEPTH];

  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] idx_q;
  logic [DATA_W-1:0]    data_q;
  logic                 read_q;
  logic                 oor_q;

  logic                 accept;
  logic                 enter_resp;
  logic                 in_oor;

  // Access operands: with zero wait states the RESP entry edge is the accept
  // edge itself, so the live inputs must be used instead of the latches.
  logic [ADDR_BITS-1:0] acc_idx;
  logic [DATA_W-1:0]    acc_data;
  logic                 acc_read;
  logic                 acc_oor;

  assign acc_idx  = (state == S_IDLE) ? address_in[ADDR_BITS-1:0] : idx_q;
  assign acc_data = (state == S_IDLE) ? RAM_in : data_q;
  assign acc_read = (state == S_IDLE) ? RW     : read_q;
  assign acc_oor  = (state == S_IDLE) ? in_oor : oor_q;

`ifdef OOR_CHECK_EN
  assign in_oor = |address_in[31:ADDR_BITS];
`else
  // Upper address bits alias onto the index; they are deliberately unused.
  logic unused_addr_hi;
  assign unused_addr_hi = |address_in[31:ADDR_BITS];
  assign in_oor         = 1'b0;
`endif

  assign mem_ready = (state == S_RESP);
  assign mem_busy  = (state != S_IDLE);
  assign mem_err   = (state == S_RESP) && oor_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; RW=0 with str_enable=0 is a NOP and is never accepted.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (memory_enable && (RW || str_enable)) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            next_state = S_RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          next_state = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Request latches, wait counter and read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      idx_q   <= '0;
      data_q  <= '0;
      read_q  <= 1'b0;
      oor_q   <= 1'b0;
      RAM_out <= '0;
    end else begin
      if (accept) begin
        idx_q  <= address_in[ADDR_BITS-1:0];
        data_q <= RAM_in;
        read_q <= RW;
        oor_q  <= in_oor;
        cnt    <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp && acc_read) begin
        RAM_out <= acc_oor ? OOR_READ_VALUE : mem[acc_idx];
      end
    end
  end

  // Array write at the RESP entry edge only; contents survive reset, and an
  // edge seen while reset is asserted never commits.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && !acc_read && !acc_oor) begin
      mem[acc_idx] <= acc_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_ram_responder
//  Purpose  : Directed self-checking bench for data_ram_responder
//             (WAIT_CYCLES=1, ADDR_BITS=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memory_enable;
  logic        RW;
  logic        str_enable;
  logic [31:0] address_in;
  logic [31:0] RAM_in;
  logic [31:0] RAM_out;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_err;

  int errors = 0;
  int checks = 0;

  data_ram_responder #(
    .DATA_W      (32),
    .ADDR_BITS   (8),
    .WAIT_CYCLES (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .memory_enable (memory_enable),
    .RW            (RW),
    .str_enable    (str_enable),
    .address_in    (address_in),
    .RAM_in        (RAM_in),
    .RAM_out       (RAM_out),
    .mem_ready     (mem_ready),
    .mem_busy      (mem_busy),
    .mem_err       (mem_err)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access driven from a negedge; returns latency (negedges from accept to
  // mem_ready), the read data and mem_err seen with the pulse. Ends in IDLE.
  task automatic access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdat, output logic err);
    memory_enable = 1'b1;
    RW            = rw;
    str_enable    = ~rw;
    address_in    = addr;
    RAM_in        = wdata;
    @(negedge clk);
    memory_enable = 1'b0;
    str_enable    = 1'b0;
    lat = 1;
    while (mem_ready !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdat = RAM_out;
    err  = mem_err;
    @(negedge clk);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
    int          lat;
    logic [31:0] rdat;
    logic        err;
    access(1'b0, addr, wdata, lat, rdat, err);
    chk({tag, "_lat"}, lat, 32'd2);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr,
                    input logic [31:0] exp_data, input logic exp_err);
    int          lat;
    logic [31:0] rdat;
    logic        err;
    access(1'b1, addr, 32'h0, lat, rdat, err);
    chk({tag, "_lat"},  lat, 32'd2);
    chk({tag, "_data"}, rdat, exp_data);
    chk({tag, "_err"},  {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    logic [6:1]  ready_seen;
    logic [31:0] d_first;
    logic [31:0] d_second;
    logic        any_act;

    rst_n         = 1'b0;
    memory_enable = 1'b0;
    RW            = 1'b0;
    str_enable    = 1'b0;
    address_in    = 32'h0;
    RAM_in        = 32'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ram_out", RAM_out, 32'h0);
    chk("rst_ready",   {31'd0, mem_ready}, 32'd0);
    chk("rst_busy",    {31'd0, mem_busy},  32'd0);
    chk("rst_err",     {31'd0, mem_err},   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read back, two-cycle latency each.
    wr("wr5", 32'd5, 32'hA5A5_0001);
    chk("idle_busy_after_wr", {31'd0, mem_busy}, 32'd0);
    rd("rd5", 32'd5, 32'hA5A5_0001, 1'b0);

    // Reset while a write sits in WAIT: aborted, outputs clear at once.
    memory_enable = 1'b1; RW = 1'b0; str_enable = 1'b1;
    address_in = 32'd5; RAM_in = 32'h1111_2222;
    @(negedge clk);
    chk("wait_busy", {31'd0, mem_busy}, 32'd1);
    memory_enable = 1'b0; str_enable = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ram_out", RAM_out, 32'h0);
    chk("abort_ready",   {31'd0, mem_ready}, 32'd0);
    chk("abort_busy",    {31'd0, mem_busy},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd("rd5_after_abort", 32'd5, 32'hA5A5_0001, 1'b0);

    // Back-to-back reads with memory_enable held high.
    wr("wr3", 32'd3, 32'h0000_3333);
    wr("wr4", 32'd4, 32'h0000_4444);
    memory_enable = 1'b1; RW = 1'b1; str_enable = 1'b0; address_in = 32'd3;
    ready_seen = '0; d_first = '0; d_second = '0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      ready_seen[i] = mem_ready;
      if (i == 1) address_in = 32'd4;
      if (i == 2) d_first = RAM_out;
      if (i == 3) chk("b2b_idle_busy", {31'd0, mem_busy}, 32'd0);
      if (i == 4) memory_enable = 1'b0;
      if (i == 5) d_second = RAM_out;
    end
    chk("b2b_ready_pattern", {26'd0, ready_seen}, {26'd0, 6'b010010});
    chk("b2b_data3", d_first,  32'h0000_3333);
    chk("b2b_data4", d_second, 32'h0000_4444);

    // NOP request: RW=0, str_enable=0.
    memory_enable = 1'b1; RW = 1'b0; str_enable = 1'b0; address_in = 32'd3;
    any_act = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      any_act = any_act | mem_busy | mem_ready;
    end
    memory_enable = 1'b0;
    chk("nop_activity", {31'd0, any_act}, 32'd0);
    chk("nop_ram_out",  RAM_out, 32'h0000_4444);

    // Inputs changed during WAIT are ignored.
    wr("wr8", 32'd8, 32'h8888_0008);
    memory_enable = 1'b1; RW = 1'b0; str_enable = 1'b1;
    address_in = 32'd7; RAM_in = 32'h7777_0007;
    @(negedge clk);
    memory_enable = 1'b0; RW = 1'b1; str_enable = 1'b0;
    address_in = 32'd8; RAM_in = 32'h0000_0BAD;
    @(negedge clk);
    chk("latch_ready", {31'd0, mem_ready}, 32'd1);
    @(negedge clk);
    RW = 1'b0;
    rd("rd7", 32'd7, 32'h7777_0007, 1'b0);
    rd("rd8", 32'd8, 32'h8888_0008, 1'b0);

    // Top index and address above the array.
    wr("wr255", 32'd255, 32'h0000_00FF);
    rd("rd255", 32'd255, 32'h0000_00FF, 1'b0);
    wr("wr0", 32'd0, 32'h0000_00AA);
    wr("wr205", 32'h0000_0205, 32'hCAFE_0205);
`ifdef OOR_CHECK_EN
    rd("rd100", 32'h0000_0100, 32'hDEAD_BEEF, 1'b1);
    rd("rd5_oor", 32'd5, 32'hA5A5_0001, 1'b0);
`else
    rd("rd100", 32'h0000_0100, 32'h0000_00AA, 1'b0);
    rd("rd5_alias", 32'd5, 32'hCAFE_0205, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
